// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: write port, digit enables and display lines of the 7-seg scanner
// master drives wr_en/wr_addr/wr_data/wr_dp/digit_en; slave drives seg/dp/an (all active-low).
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int AW = $clog2(NUM_DIGITS);
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  wr_dp;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  modport master (output wr_en, wr_addr, wr_data, wr_dp, digit_en, input seg, dp, an);
  modport slave (input wr_en, wr_addr, wr_data, wr_dp, digit_en, output seg, dp, an);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment scanner with per-digit register file
// Ports: clk, rst_n (sync active-low), bus (slave): write port + digit_en in, seg/dp/an out.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV = 100000,
  localparam int AW = $clog2(NUM_DIGITS)
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_idx;
  logic [3:0]            r_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_dp;
  logic                  w_tick;
  logic                  w_wr;
  logic                  w_on;
  logic [NUM_DIGITS-1:0] w_show;
  assign w_tick = r_cnt == CW'(CLK_DIV - 1);
  assign w_wr = bus.wr_en && ({1'b0, bus.wr_addr} < (AW + 1)'(NUM_DIGITS));
  // w_show[i] stays high unless everything from digit i upward is a plain zero
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_any;
  always_comb begin
    w_show = '1;
    w_any = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_any = w_any | (r_dig[i] != 4'd0) | r_dp[i];
      w_show[i] = w_any;
    end
  end
`else
  always_comb w_show = '1;
`endif
  assign w_on = bus.digit_en[r_idx] & w_show[r_idx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_dp <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= '0;
      bus.seg <= 7'h7F;
      bus.dp <= 1'b1;
      bus.an <= '1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= (r_idx == AW'(NUM_DIGITS - 1)) ? '0 : r_idx + AW'(1);
      if (w_wr) begin
        r_dig[bus.wr_addr] <= bus.wr_data;
        r_dp[bus.wr_addr] <= bus.wr_dp;
      end
      bus.seg <= w_on ? SEG[r_dig[r_idx]] : 7'h7F;
      bus.dp <= ~(w_on & r_dp[r_idx]);
      bus.an <= w_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: 8-digit and 6-digit scanners checked against a cycle-count model
module tb_seg7_scan_ctrl;
  localparam int CD = 4;
  localparam logic [6:0] SEG_T [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic wr_dp = 1'b0;
  logic [7:0] en = 8'hFF;
  int n_tot = 0;
  int n_bad = 0;
  int k = 0;
  logic [3:0] mem [2][8];
  bit dpm [2][8];
  always #5 clk = ~clk;
  seg7_scan_ctrl_if #(.NUM_DIGITS(8)) b8 ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(6)) b6 ();
  assign b8.wr_en = wr_en;
  assign b8.wr_addr = wr_addr;
  assign b8.wr_data = wr_data;
  assign b8.wr_dp = wr_dp;
  assign b8.digit_en = en;
  assign b6.wr_en = wr_en;
  assign b6.wr_addr = wr_addr;
  assign b6.wr_data = wr_data;
  assign b6.wr_dp = wr_dp;
  assign b6.digit_en = en[5:0];
  seg7_scan_ctrl #(.NUM_DIGITS(8), .CLK_DIV(CD)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  seg7_scan_ctrl #(.NUM_DIGITS(6), .CLK_DIV(CD)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  task automatic step();
    logic [6:0] es [2];
    logic ed [2];
    logic [7:0] ea [2];
    int idx, nd;
    bit on, any;
    for (int u = 0; u < 2; u++) begin
      nd = (u == 0) ? 8 : 6;
      es[u] = 7'h7F;
      ed[u] = 1'b1;
      ea[u] = 8'hFF;
      if (rst_n) begin
        idx = (k / CD) % nd;
        on = en[idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        any = 1'b0;
        for (int j = idx; j < nd; j++) any |= (mem[u][j] != 4'd0) || dpm[u][j];
        if (idx > 0 && !any) on = 1'b0;
`else
        any = 1'b1;
`endif
        if (on) begin
          es[u] = SEG_T[mem[u][idx]];
          ed[u] = ~dpm[u][idx];
          ea[u] = ~(8'd1 << idx);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("seg8", 16'(b8.seg), 16'(es[0]));
    chk("dp8", 16'(b8.dp), 16'(ed[0]));
    chk("an8", 16'(b8.an), 16'(ea[0]));
    chk("seg6", 16'(b6.seg), 16'(es[1]));
    chk("dp6", 16'(b6.dp), 16'(ed[1]));
    chk("an6", 16'(b6.an), 16'(ea[1][5:0]));
    if (!rst_n) begin
      for (int u = 0; u < 2; u++)
        for (int j = 0; j < 8; j++) begin
          mem[u][j] = '0;
          dpm[u][j] = 1'b0;
        end
      k = 0;
    end else begin
      if (wr_en) begin
        mem[0][wr_addr] = wr_data;
        dpm[0][wr_addr] = wr_dp;
        if (wr_addr < 3'd6) begin
          mem[1][wr_addr] = wr_data;
          dpm[1][wr_addr] = wr_dp;
        end
      end
      k++;
    end
  endtask
  task automatic wr(input int a, input int d, input bit p);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_data = 4'(d);
    wr_dp = p;
    step();
    wr_en = 1'b0;
  endtask
  task automatic load(input logic [31:0] v);
    for (int i = 0; i < 8; i++) wr(i, int'(v[i*4+:4]), 1'b0);
  endtask
  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    load(32'h6295_1413);
    repeat (40) step();
    for (int t = 0; t < 64 && !(((k / CD) % 8) == 2 && (k % CD) == 1); t++) step();
    wr(2, 'hC, 1'b1);
    repeat (4) step();
    en = 8'hFE;
    repeat (40) step();
    en = 8'hFF;
    wr(7, 'hF, 1'b1);
    wr(6, 'hE, 1'b1);
    repeat (50) step();
    for (int t = 0; t < 64 && !(((k / CD) % 8) == 5 && (k % CD) == 1); t++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    load(32'h0070_0000);
    repeat (40) step();
    load(32'h0000_0000);
    repeat (40) step();
    wr(0, 'h5, 1'b0);
    wr(3, 'h0, 1'b1);
    repeat (40) step();
    repeat (3000) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      wr_dp = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
